mem_access_unit: RTL and testbench
==================================

// Module: mem_access_unit
// PURPOSE
//  MEM-stage responder for the load/store requests the EX stage issues (addr, write data, aluop, mem_rw).
//  Performs byte-serial, little-endian accesses on the 8-bit RAM port, sign/zero-extends loads.
//  Stalls the pipeline until done; passes non-memory results to writeback unchanged.
// PARAMETERS
//  ADDR_W  32  RAM byte-address width; addresses wrap modulo 2^ADDR_W
// PORTS
//  clk          in   1       rising-edge clock
//  rst          in   1       reset, synchronous, active-high
//  rdy_i        in   1       global enable; low = freeze FSM, no RAM write
//  req_i        in   1       memory op requested (EX mem_rw)
//  aluop_i      in   AluOp   `EXE_{LW,LH,LB,LHU,LBU,SW,SH,SB}_OP from define.v
//  addr_i       in   ADDR_W  effective byte address
//  st_data_i    in   32      store data (low bytes used for SH/SB)
//  alu_res_i    in   32      EX result for non-memory instructions
//  wd_i         in   5       destination register
//  wreg_i       in   1       destination write enable
//  ram_din_i    in   8       RAM read byte (1-cycle latency)
//  ram_addr_o   out  ADDR_W  RAM byte address
//  ram_dout_o   out  8       RAM write byte
//  ram_wr_o     out  1       1 = write this cycle, 0 = read
//  stall_req_o  out  1       hold IF/ID/EX/MEM pipeline registers
//  wd_o         out  5       to writeback
//  wreg_o       out  1       to writeback
//  wdata_o      out  32      to writeback
// BEHAVIOUR
//  Reset: state IDLE, cnt 0, load buffer 0; all outputs 0 while rst high and the cycle after.
//  Size N: W=4, H/HU=2, B/BU=1. Byte k at addr+k, mapped to bits [8k+7:8k].
//  States: IDLE, BUSY, DONE. rdy_i low: state/cnt/buffer held, ram_wr_o=0.
//  IDLE, req_i=0: wd_o=wd_i, wreg_o=wreg_i, wdata_o=alu_res_i (combinational), stall 0.
//  IDLE, req_i=1: stall_req_o=1 same cycle; latch op/addr/data/wd/wreg; cnt<=0; ->BUSY.
//   Unrecognised aluop with req_i: ->DONE directly, no RAM access, wreg_o=0.
//  BUSY store: cycle k (k=0..N-1) ram_addr_o=addr+k, ram_dout_o=byte k, ram_wr_o=1;
//   after k=N-1 ->DONE. N busy cycles.
//  BUSY load: cycle k (k=0..N) ram_addr_o=addr+min(k,N-1), ram_wr_o=0;
//   for k>=1 capture ram_din_i into buffer byte k-1; after k=N ->DONE. N+1 busy cycles.
//  BUSY: stall_req_o=1, wreg_o=0.
//  DONE (one cycle): stall_req_o=0; wd_o=latched wd.
//   Load: wreg_o=latched wreg, wdata_o = buffer extended: LB sign bit7, LH sign bit15, LBU/LHU zero.
//   Store: wreg_o=0, wdata_o=0. Next state IDLE unconditionally (req_i still high is ignored).
//  Total latency request->DONE: load N+2 cycles, store N+1 cycles.
//  ram_wr_o never high outside BUSY-store. Inputs ignored while BUSY (values latched).
//  Address increment wraps at 2^ADDR_W (e.g. LH at all-ones reads all-ones then 0).
//  rst mid-access: next cycle IDLE, ram_wr_o=0; partial store bytes remain written, load discarded.
// TESTING
//  LW @0x100, RAM 78 56 34 12 -> addr 100..103 seq, stall 5 cycles, DONE wdata_o=0x12345678, wreg_o=1.
//  LB @0x40 RAM 0x80 -> 0xFFFFFF80; LBU same -> 0x00000080; LH RAM 00 80 -> 0xFFFF8000.
//  SH data 0x0000ABCD @0x20 -> wr CD@0x20, AB@0x21, 2 busy cycles, DONE wreg_o=0.
//  LW with rdy_i low 3 cycles mid-BUSY -> cnt frozen, no wr, result still 0x12345678, 8 stall cycles.
//  SW 0xDEADBEEF @0x10, rst after 2nd byte -> only EF,BE written; IDLE, outputs 0.
//  req_i=0, alu_res_i=0x55, wd_i=3 -> same-cycle wdata_o=0x55, wd_o=3, stall 0; back-to-back LW, LW -> DONE then IDLE then BUSY.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage load/store responder: byte-serial little-endian RAM access,
// load extension, pipeline stall, and pass-through of non-memory results.
//
// Ports:
//   clk, rst             clock, synchronous active-high reset
//   rdy_i                global enable (low freezes FSM, blocks RAM writes)
//   req_i, aluop_i       memory request and load/store opcode
//   addr_i, st_data_i    effective byte address, store data
//   alu_res_i, wd_i,
//   wreg_i               EX result / destination for the writeback path
//   ram_din_i            RAM read byte (1-cycle latency)
//   ram_addr_o,
//   ram_dout_o, ram_wr_o RAM byte port
//   stall_req_o          hold upstream pipeline registers
//   wd_o, wreg_o,
//   wdata_o              writeback bundle
module mem_access_unit #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rdy_i,
    input  logic              req_i,
    input  logic [7:0]        aluop_i,
    input  logic [ADDR_W-1:0] addr_i,
    input  logic [31:0]       st_data_i,
    input  logic [31:0]       alu_res_i,
    input  logic [4:0]        wd_i,
    input  logic              wreg_i,
    input  logic [7:0]        ram_din_i,
    output logic [ADDR_W-1:0] ram_addr_o,
    output logic [7:0]        ram_dout_o,
    output logic              ram_wr_o,
    output logic              stall_req_o,
    output logic [4:0]        wd_o,
    output logic              wreg_o,
    output logic [31:0]       wdata_o
);

    localparam logic [7:0] OP_LB  = 8'b1110_0000;
    localparam logic [7:0] OP_LH  = 8'b1110_0001;
    localparam logic [7:0] OP_LW  = 8'b1110_0011;
    localparam logic [7:0] OP_LBU = 8'b1110_0100;
    localparam logic [7:0] OP_LHU = 8'b1110_0101;
    localparam logic [7:0] OP_SB  = 8'b1110_1000;
    localparam logic [7:0] OP_SH  = 8'b1110_1001;
    localparam logic [7:0] OP_SW  = 8'b1110_1011;

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    function automatic logic op_valid(input logic [7:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU,
            OP_SB, OP_SH, OP_SW: op_valid = 1'b1;
            default:             op_valid = 1'b0;
        endcase
    endfunction

    function automatic logic op_load(input logic [7:0] op);
        case (op)
            OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: op_load = 1'b1;
            default:                             op_load = 1'b0;
        endcase
    endfunction

    function automatic logic [2:0] op_len(input logic [7:0] op);
        case (op)
            OP_LW, OP_SW:         op_len = 3'd4;
            OP_LH, OP_LHU, OP_SH: op_len = 3'd2;
            default:              op_len = 3'd1;
        endcase
    endfunction

    state_t            state;
    logic [2:0]        cnt;
    logic [7:0]        op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [31:0]       data_q;
    logic [31:0]       buf_q;
    logic [4:0]        wd_q;
    logic              wreg_q;

    logic              q_load;
    logic [2:0]        q_len;
    logic [2:0]        q_last;
    logic [1:0]        cnt_m1;
    logic [2:0]        off;
    logic [31:0]       ext;

    assign q_load = op_load(op_q);
    assign q_len  = op_len(op_q);
    assign q_last = q_len - 3'd1;
    assign cnt_m1 = cnt[1:0] - 2'd1;

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            op_q   <= '0;
            addr_q <= '0;
            data_q <= '0;
            buf_q  <= '0;
            wd_q   <= '0;
            wreg_q <= 1'b0;
        end else if (rdy_i) begin
            unique case (state)
                IDLE: begin
                    if (req_i) begin
                        op_q   <= aluop_i;
                        addr_q <= addr_i;
                        data_q <= st_data_i;
                        wd_q   <= wd_i;
                        wreg_q <= wreg_i;
                        cnt    <= '0;
                        state  <= op_valid(aluop_i) ? BUSY : DONE;
                    end
                end
                BUSY: begin
                    // Read data lags the address by one cycle.
                    if (q_load && cnt != 3'd0)
                        buf_q[{cnt_m1, 3'b000} +: 8] <= ram_din_i;
                    if (cnt == (q_load ? q_len : q_last))
                        state <= DONE;
                    else
                        cnt <= cnt + 3'd1;
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    // While frozen, keep presenting the last byte already requested so
    // that the RAM output on the resume cycle is still byte cnt-1.
    always_comb begin
        off = cnt;
        if (!rdy_i)
            off = (cnt == 3'd0) ? 3'd0 : cnt - 3'd1;
        else if (cnt > q_last)
            off = q_last;
    end

    always_comb begin
        ext = buf_q;
        case (op_q)
            OP_LB:   ext = {{24{buf_q[7]}}, buf_q[7:0]};
            OP_LBU:  ext = {24'd0, buf_q[7:0]};
            OP_LH:   ext = {{16{buf_q[15]}}, buf_q[15:0]};
            OP_LHU:  ext = {16'd0, buf_q[15:0]};
            default: ext = buf_q;
        endcase
    end

    always_comb begin
        ram_addr_o  = '0;
        ram_dout_o  = '0;
        ram_wr_o    = 1'b0;
        stall_req_o = 1'b0;
        wd_o        = '0;
        wreg_o      = 1'b0;
        wdata_o     = '0;
        if (!rst) begin
            unique case (state)
                IDLE: begin
                    stall_req_o = req_i;
                    if (!req_i) begin
                        wd_o    = wd_i;
                        wreg_o  = wreg_i;
                        wdata_o = alu_res_i;
                    end
                end
                BUSY: begin
                    stall_req_o = 1'b1;
                    ram_addr_o  = addr_q + ADDR_W'(off);
                    if (!q_load) begin
                        ram_dout_o = data_q[{cnt[1:0], 3'b000} +: 8];
                        ram_wr_o   = rdy_i;
                    end
                end
                DONE: begin
                    wd_o = wd_q;
                    if (q_load) begin
                        wreg_o  = wreg_q;
                        wdata_o = ext;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed self-checking bench for mem_access_unit with a byte RAM model.
// One task per scenario; expected values are hand-computed constants.
module tb_mem_access_unit;

    localparam logic [7:0] LB  = 8'b1110_0000;
    localparam logic [7:0] LH  = 8'b1110_0001;
    localparam logic [7:0] LW  = 8'b1110_0011;
    localparam logic [7:0] LBU = 8'b1110_0100;
    localparam logic [7:0] LHU = 8'b1110_0101;
    localparam logic [7:0] SH  = 8'b1110_1001;
    localparam logic [7:0] SW  = 8'b1110_1011;

    logic        clk = 1'b0;
    logic        rst;
    logic        rdy_i;
    logic        req_i;
    logic [7:0]  aluop_i;
    logic [31:0] addr_i;
    logic [31:0] st_data_i;
    logic [31:0] alu_res_i;
    logic [4:0]  wd_i;
    logic        wreg_i;
    logic [7:0]  ram_din_i;
    logic [31:0] ram_addr_o;
    logic [7:0]  ram_dout_o;
    logic        ram_wr_o;
    logic        stall_req_o;
    logic [4:0]  wd_o;
    logic        wreg_o;
    logic [31:0] wdata_o;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    mem_access_unit #(.ADDR_W(32)) dut (
        .clk(clk), .rst(rst), .rdy_i(rdy_i), .req_i(req_i),
        .aluop_i(aluop_i), .addr_i(addr_i), .st_data_i(st_data_i),
        .alu_res_i(alu_res_i), .wd_i(wd_i), .wreg_i(wreg_i),
        .ram_din_i(ram_din_i), .ram_addr_o(ram_addr_o),
        .ram_dout_o(ram_dout_o), .ram_wr_o(ram_wr_o),
        .stall_req_o(stall_req_o), .wd_o(wd_o), .wreg_o(wreg_o),
        .wdata_o(wdata_o)
    );

    logic [7:0]  mem [4096];
    logic        pl_en = 1'b0;
    logic [11:0] pl_a = '0;
    logic [7:0]  pl_d = '0;

    always @(posedge clk) begin
        if (pl_en)
            mem[pl_a] <= pl_d;
        else if (ram_wr_o)
            mem[ram_addr_o[11:0]] <= ram_dout_o;
        ram_din_i <= mem[ram_addr_o[11:0]];
    end

    logic [31:0] alog [16];
    int          nlog, wr_cnt, wr_frozen, busy_wreg_bad, busy;
    logic        req_stall, tout, d_wreg;
    logic [31:0] d_wdata;
    logic [4:0]  d_wd;

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic poke(input logic [11:0] a, input logic [7:0] d);
        pl_en = 1'b1;
        pl_a  = a;
        pl_d  = d;
        tick();
        pl_en = 1'b0;
    endtask

    task automatic run_op(input logic [7:0] op, input logic [31:0] a,
                          input logic [31:0] d, input logic [4:0] wd,
                          input logic w, input int fz_at,
                          input int fz_len);
        req_i = 1'b1; aluop_i = op; addr_i = a; st_data_i = d;
        wd_i = wd; wreg_i = w; alu_res_i = 32'hCAFE0000; rdy_i = 1'b1;
        #1;
        req_stall = stall_req_o;
        tick();
        req_i = 1'b0; aluop_i = 8'h00; addr_i = 32'h0BAD0000;
        st_data_i = 32'h55555555; wd_i = 5'd31; wreg_i = 1'b1;
        nlog = 0; wr_cnt = 0; wr_frozen = 0; busy_wreg_bad = 0;
        busy = 0; tout = 1'b1;
        d_wdata = '0; d_wreg = 1'b0; d_wd = '0;
        for (int c = 0; c < 40; c++) begin
            rdy_i = !(c >= fz_at && c < fz_at + fz_len);
            #1;
            if (!stall_req_o) begin
                tout = 1'b0;
                d_wdata = wdata_o;
                d_wreg = wreg_o;
                d_wd = wd_o;
                break;
            end
            if (rdy_i) begin
                if (nlog < 16) alog[nlog] = ram_addr_o;
                nlog++;
                if (ram_wr_o) wr_cnt++;
            end else if (ram_wr_o) begin
                wr_frozen++;
            end
            if (wreg_o) busy_wreg_bad++;
            busy++;
            tick();
        end
        rdy_i = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b1; rdy_i = 1'b1; req_i = 1'b0; aluop_i = '0;
        addr_i = '0; st_data_i = '0; alu_res_i = 32'h77;
        wd_i = 5'd5; wreg_i = 1'b1;
        tick();
        tick();
        #1;
        checks++; if (wdata_o !== 32'h0) begin errors++;
            $display("FAIL rst_wdata: got %h want 0", wdata_o); end
        checks++; if (wd_o !== 5'd0) begin errors++;
            $display("FAIL rst_wd: got %0d want 0", wd_o); end
        checks++; if (wreg_o !== 1'b0 || stall_req_o !== 1'b0) begin errors++;
            $display("FAIL rst_ctl: wreg %b stall %b want 0 0", wreg_o, stall_req_o); end
        checks++; if (ram_wr_o !== 1'b0) begin errors++;
            $display("FAIL rst_wr: got %b want 0", ram_wr_o); end
        alu_res_i = '0; wd_i = '0; wreg_i = 1'b0;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (wdata_o !== 32'h0 || stall_req_o !== 1'b0 || ram_addr_o !== 32'h0) begin
            errors++;
            $display("FAIL rst_after: wdata %h stall %b addr %h want 0", wdata_o, stall_req_o, ram_addr_o); end
        tick();
    endtask

    task automatic test_passthrough();
        req_i = 1'b0; alu_res_i = 32'h55; wd_i = 5'd3; wreg_i = 1'b1;
        #1;
        checks++; if (wdata_o !== 32'h55) begin errors++;
            $display("FAIL pass_wdata: got %h want 00000055", wdata_o); end
        checks++; if (wd_o !== 5'd3 || wreg_o !== 1'b1) begin errors++;
            $display("FAIL pass_wd: wd %0d wreg %b want 3 1", wd_o, wreg_o); end
        checks++; if (stall_req_o !== 1'b0) begin errors++;
            $display("FAIL pass_stall: got %b want 0", stall_req_o); end
        alu_res_i = 32'h1234;
        #1;
        checks++; if (wdata_o !== 32'h1234) begin errors++;
            $display("FAIL pass_comb: got %h want 00001234", wdata_o); end
        tick();
    endtask

    task automatic test_lw();
        poke(12'h100, 8'h78); poke(12'h101, 8'h56);
        poke(12'h102, 8'h34); poke(12'h103, 8'h12);
        run_op(LW, 32'h100, 32'h0, 5'd7, 1'b1, 0, 0);
        checks++; if (req_stall !== 1'b1) begin errors++;
            $display("FAIL lw_req_stall: got %b want 1", req_stall); end
        checks++; if (tout !== 1'b0 || busy != 5) begin errors++;
            $display("FAIL lw_busy: timeout %b busy %0d want 0 5", tout, busy); end
        for (int i = 0; i < 5; i++) begin
            checks++;
            if (alog[i] !== 32'h100 + 32'(i > 3 ? 3 : i)) begin errors++;
                $display("FAIL lw_addr%0d: got %h want %h", i, alog[i], 32'h100 + 32'(i > 3 ? 3 : i)); end
        end
        checks++; if (wr_cnt != 0 || busy_wreg_bad != 0) begin errors++;
            $display("FAIL lw_busy_ctl: wr %0d wreg %0d want 0 0", wr_cnt, busy_wreg_bad); end
        checks++; if (d_wdata !== 32'h12345678) begin errors++;
            $display("FAIL lw_data: got %h want 12345678", d_wdata); end
        checks++; if (d_wreg !== 1'b1 || d_wd !== 5'd7) begin errors++;
            $display("FAIL lw_wb: wreg %b wd %0d want 1 7", d_wreg, d_wd); end
        tick();
        #1;
        checks++; if (stall_req_o !== 1'b0 || wdata_o !== 32'hCAFE0000) begin errors++;
            $display("FAIL lw_idle: stall %b wdata %h want 0 cafe0000", stall_req_o, wdata_o); end
        tick();
    endtask

    task automatic test_lw_freeze();
        run_op(LW, 32'h100, 32'h0, 5'd8, 1'b1, 2, 3);
        checks++; if (tout !== 1'b0 || busy != 8) begin errors++;
            $display("FAIL frz_busy: timeout %b busy %0d want 0 8", tout, busy); end
        checks++; if (wr_frozen != 0 || nlog != 5) begin errors++;
            $display("FAIL frz_ctl: frozen wr %0d active %0d want 0 5", wr_frozen, nlog); end
        checks++; if (d_wdata !== 32'h12345678) begin errors++;
            $display("FAIL frz_data: got %h want 12345678", d_wdata); end
        tick();
    endtask

    task automatic test_byte_half();
        poke(12'h040, 8'h80);
        run_op(LB, 32'h40, 32'h0, 5'd1, 1'b1, 0, 0);
        checks++; if (busy != 2 || d_wdata !== 32'hFFFFFF80 || d_wreg !== 1'b1) begin
            errors++;
            $display("FAIL lb: busy %0d data %h wreg %b want 2 ffffff80 1", busy, d_wdata, d_wreg); end
        tick();
        run_op(LBU, 32'h40, 32'h0, 5'd1, 1'b1, 0, 0);
        checks++; if (d_wdata !== 32'h00000080) begin errors++;
            $display("FAIL lbu: got %h want 00000080", d_wdata); end
        tick();
        poke(12'h050, 8'h00); poke(12'h051, 8'h80);
        run_op(LH, 32'h50, 32'h0, 5'd2, 1'b1, 0, 0);
        checks++; if (busy != 3 || d_wdata !== 32'hFFFF8000) begin errors++;
            $display("FAIL lh: busy %0d data %h want 3 ffff8000", busy, d_wdata); end
        tick();
        run_op(LHU, 32'h50, 32'h0, 5'd2, 1'b1, 0, 0);
        checks++; if (d_wdata !== 32'h00008000) begin errors++;
            $display("FAIL lhu: got %h want 00008000", d_wdata); end
        tick();
    endtask

    task automatic test_wrap();
        poke(12'hFFF, 8'h11); poke(12'h000, 8'h22);
        run_op(LH, 32'hFFFFFFFF, 32'h0, 5'd4, 1'b1, 0, 0);
        checks++; if (alog[0] !== 32'hFFFFFFFF || alog[1] !== 32'h0 || alog[2] !== 32'h0) begin
            errors++;
            $display("FAIL wrap_addr: got %h %h %h want ffffffff 0 0", alog[0], alog[1], alog[2]); end
        checks++; if (d_wdata !== 32'h00002211) begin errors++;
            $display("FAIL wrap_data: got %h want 00002211", d_wdata); end
        tick();
    endtask

    task automatic test_sh();
        poke(12'h022, 8'h5A);
        run_op(SH, 32'h20, 32'h0000ABCD, 5'd9, 1'b1, 0, 0);
        checks++; if (tout !== 1'b0 || busy != 2 || wr_cnt != 2) begin errors++;
            $display("FAIL sh_busy: busy %0d wr %0d want 2 2", busy, wr_cnt); end
        checks++; if (alog[0] !== 32'h20 || alog[1] !== 32'h21) begin errors++;
            $display("FAIL sh_addr: got %h %h want 20 21", alog[0], alog[1]); end
        checks++; if (d_wreg !== 1'b0 || d_wdata !== 32'h0 || d_wd !== 5'd9) begin errors++;
            $display("FAIL sh_wb: wreg %b data %h wd %0d want 0 0 9", d_wreg, d_wdata, d_wd); end
        checks++; if (mem[12'h020] !== 8'hCD || mem[12'h021] !== 8'hAB || mem[12'h022] !== 8'h5A) begin
            errors++;
            $display("FAIL sh_mem: got %h %h %h want cd ab 5a", mem[12'h020], mem[12'h021], mem[12'h022]); end
        tick();
    endtask

    task automatic test_bad_op();
        run_op(8'h55, 32'h20, 32'h0, 5'd9, 1'b1, 0, 0);
        checks++; if (req_stall !== 1'b1 || tout !== 1'b0 || busy != 0) begin errors++;
            $display("FAIL bad_lat: stall %b busy %0d want 1 0", req_stall, busy); end
        checks++; if (d_wreg !== 1'b0 || d_wd !== 5'd9 || wr_cnt != 0) begin errors++;
            $display("FAIL bad_wb: wreg %b wd %0d wr %0d want 0 9 0", d_wreg, d_wd, wr_cnt); end
        tick();
    endtask

    task automatic test_back_to_back();
        int n;
        run_op(LW, 32'h100, 32'h0, 5'd4, 1'b1, 0, 0);
        checks++; if (d_wdata !== 32'h12345678) begin errors++;
            $display("FAIL b2b_first: got %h want 12345678", d_wdata); end
        req_i = 1'b1; aluop_i = LW; addr_i = 32'h100; wd_i = 5'd6; wreg_i = 1'b1;
        #1;
        checks++; if (stall_req_o !== 1'b0) begin errors++;
            $display("FAIL b2b_done: stall %b want 0", stall_req_o); end
        tick();
        #1;
        checks++; if (stall_req_o !== 1'b1 || wreg_o !== 1'b0) begin errors++;
            $display("FAIL b2b_idle: stall %b wreg %b want 1 0", stall_req_o, wreg_o); end
        tick();
        req_i = 1'b0;
        #1;
        checks++; if (stall_req_o !== 1'b1 || ram_addr_o !== 32'h100) begin errors++;
            $display("FAIL b2b_busy: stall %b addr %h want 1 100", stall_req_o, ram_addr_o); end
        n = 0;
        for (int c = 0; c < 20; c++) begin
            tick();
            #1;
            if (!stall_req_o) break;
            n++;
        end
        checks++; if (n != 4 || wdata_o !== 32'h12345678 || wd_o !== 5'd6) begin errors++;
            $display("FAIL b2b_second: more busy %0d data %h wd %0d want 4 12345678 6", n, wdata_o, wd_o); end
        tick();
    endtask

    task automatic test_reset_mid_store();
        alu_res_i = '0; wd_i = '0; wreg_i = 1'b0;
        poke(12'h010, 8'h00); poke(12'h011, 8'h00);
        poke(12'h012, 8'h00); poke(12'h013, 8'h00);
        req_i = 1'b1; aluop_i = SW; addr_i = 32'h10; st_data_i = 32'hDEADBEEF;
        tick();
        req_i = 1'b0;
        #1;
        checks++; if (ram_wr_o !== 1'b1 || ram_addr_o !== 32'h10 || ram_dout_o !== 8'hEF) begin
            errors++;
            $display("FAIL sw_b0: wr %b addr %h dout %h want 1 10 ef", ram_wr_o, ram_addr_o, ram_dout_o); end
        tick();
        #1;
        checks++; if (ram_wr_o !== 1'b1 || ram_addr_o !== 32'h11 || ram_dout_o !== 8'hBE) begin
            errors++;
            $display("FAIL sw_b1: wr %b addr %h dout %h want 1 11 be", ram_wr_o, ram_addr_o, ram_dout_o); end
        tick();
        rst = 1'b1;
        #1;
        checks++; if (ram_wr_o !== 1'b0) begin errors++;
            $display("FAIL sw_rst_wr: got %b want 0", ram_wr_o); end
        tick();
        rst = 1'b0;
        #1;
        checks++; if (stall_req_o !== 1'b0 || wdata_o !== 32'h0 || ram_wr_o !== 1'b0 || wreg_o !== 1'b0) begin
            errors++;
            $display("FAIL sw_rst_idle: stall %b wdata %h wr %b wreg %b want 0", stall_req_o, wdata_o, ram_wr_o, wreg_o); end
        tick();
        checks++; if (mem[12'h010] !== 8'hEF || mem[12'h011] !== 8'hBE ||
                      mem[12'h012] !== 8'h00 || mem[12'h013] !== 8'h00) begin
            errors++;
            $display("FAIL sw_rst_mem: got %h %h %h %h want ef be 00 00",
                     mem[12'h010], mem[12'h011], mem[12'h012], mem[12'h013]); end
    endtask

    initial begin
        test_reset();
        test_passthrough();
        test_lw();
        test_lw_freeze();
        test_byte_half();
        test_wrap();
        test_sh();
        test_bad_op();
        test_back_to_back();
        test_reset_mid_store();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
